decoder2to4_seq: RTL

- Registered N-to-2^N decoder with a valid/ready handshake. It is the receiving end of the priority-encoder interface, which carries a code plus a zero flag.
- Each accepted non-zero request is turned into a one-hot output line. The line is held high for HOLD cycles and then followed by GAP idle cycles before the next request is accepted.
- Sits downstream of the encoder in the Lab6 datapath. Drives one-hot enables (e.g. LEDs or per-channel strobes).

---
 rtl/decoder2to4_seq_pkg.sv | 20 ++
 rtl/decoder2to4_seq_hold_counter.sv | 26 ++
 rtl/decoder2to4_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/decoder2to4_seq_pkg.sv
// Shared state codes and default sizing for the registered one-hot decoder.
// Counter preload helper converts a cycle count into a down-counter start value.
package decoder2to4_seq_pkg;

    localparam int N_DEF    = 2;
    localparam int HOLD_DEF = 4;
    localparam int GAP_DEF  = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_HOLD = 2'b01;
    localparam state_t ST_GAP  = 2'b10;

    // A phase lasting c cycles ends when the counter reaches zero, so it starts at c-1.
    function automatic logic [7:0] cnt_init(input int cycles);
        return (cycles > 0) ? 8'(cycles - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/decoder2to4_seq_hold_counter.sv
// Loadable 8-bit down-counter with a zero flag; load wins over decrement.
// Decrement stops at zero so an extra decrement request can never wrap.
module decoder2to4_seq_hold_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/decoder2to4_seq.sv
// Registered N-to-2^N decoder: accepted code -> one-hot for HOLD cycles, then GAP idle cycles; 1-cycle latency.
// in_ready is high only in IDLE (stalls upstream while busy); DECODER2TO4_SEQ_OVERRUN_EN adds overrun_cnt.
module decoder2to4_seq
    import decoder2to4_seq_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int HOLD = HOLD_DEF,
    parameter int GAP  = GAP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_zero,
    input  logic [N-1:0]      in_code,
    output logic              in_ready,
    output logic [2**N-1:0]   out_onehot,
    output logic              out_valid,
    output logic              busy
`ifdef DECODER2TO4_SEQ_OVERRUN_EN
    ,
    output logic [7:0]        overrun_cnt
`endif
);

    localparam int         W         = 2**N;
    localparam logic [7:0] HOLD_INIT = cnt_init(HOLD);
    localparam logic [7:0] GAP_INIT  = cnt_init(GAP);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_onehot;
    logic           r_out_vld;
    logic           w_take;
    logic           w_load;
    logic [7:0]     w_load_val;
    logic           w_dec;
    logic           w_cnt_zero;
    logic [W-1:0]   w_decode;

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_HOLD) || (r_state == ST_GAP);
    // A zero-flagged transfer still completes the handshake but produces nothing.
    assign w_take   = in_valid && !in_zero && in_ready;
    assign w_decode = {{(W-1){1'b0}}, 1'b1} << in_code;

    decoder2to4_seq_hold_counter u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = 8'd0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    if (GAP > 0) begin
                        w_state_nxt = ST_GAP;
                        w_load      = 1'b1;
                        w_load_val  = GAP_INIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_onehot  <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_vld <= (w_state_nxt == ST_HOLD);
            // in_code is captured only on the accept edge; HOLD just keeps the register.
            if (w_state_nxt != ST_HOLD) begin
                r_onehot <= '0;
            end else if (w_take) begin
                r_onehot <= w_decode;
            end
        end
    end

    assign out_onehot = r_onehot;
    assign out_valid  = r_out_vld;

`ifdef DECODER2TO4_SEQ_OVERRUN_EN
    logic [7:0] r_overrun_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun_cnt <= 8'd0;
        end else if (in_valid && !in_zero && (r_state != ST_IDLE) && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

endmodule
